riscv_data_mem: RTL
===================

RISCV_DATA_MEM -- requirements
Module: riscv_data_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the RAM holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter FIFO_D_LOG2, default 3, meaning the debug TX FIFO holds 2^FIFO_D_LOG2 bytes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ce_i, input, 1 bit: access enable from the CPU.
REQ-006 SHALL have port we_i, input, 1 bit: 1 means write, 0 means read; qualified by ce_i.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address from the CPU.
REQ-008 SHALL have port data_i, input, 32 bits: write data from the CPU.
REQ-009 SHALL have port data_o, output, 32 bits: registered read data returned to the CPU.
REQ-010 SHALL have port dbg_valid_o, output, 1 bit: debug FIFO is non-empty.
REQ-011 SHALL have port dbg_data_o, output, 8 bits: byte at the head of the debug FIFO.
REQ-012 SHALL have port dbg_ready_i, input, 1 bit: the debug sink accepts the head byte.

Function
REQ-013 SHALL decode the address map, with addr_i[1:0] ignored everywhere:
- addr_i[31:28]==0 selects RAM; word index is addr_i[ADDR_W+1:2]; upper bits alias.
- 0xF000_0000 selects CYCLE.
- 0xF000_0004 selects TXDATA.
- 0xF000_0008 selects STATUS.
- Any other address is unmapped.
REQ-014 SHALL have a read latency of exactly one cycle: a read (ce_i=1, we_i=0) sampled at edge N drives data_o from edge N until the next read.
REQ-015 SHALL hold data_o unchanged in cycles with no read (ce_i=0, or a write).
REQ-016 SHALL perform a RAM write of all 32 bits of data_i at the edge; a read of the same word at the following edge SHALL return the new value.
REQ-017 SHALL read all unmapped addresses as 0x0000_0000 and ignore writes to them.
REQ-018 SHALL implement CYCLE as a 32-bit counter:
- increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0;
- a write loads data_i at that edge, with no increment in that cycle;
- a read returns the value before the edge.
REQ-019 SHALL push data_i[7:0] into the FIFO on a write to TXDATA when the FIFO is not full, or when a pop occurs in the same cycle.
REQ-020 SHALL drop a TXDATA write otherwise and set the sticky overflow flag.
REQ-021 SHALL read TXDATA as 0.
REQ-022 SHALL read STATUS as {19'b0, count[4:0], 5'b0, overflow, full, empty}, where count is the FIFO occupancy, 0..2^FIFO_D_LOG2.
REQ-023 SHALL clear overflow on any write to STATUS; a clear coinciding with a new overflow SHALL leave overflow=1.
REQ-024 SHALL drive dbg_valid_o=1 exactly when count>0, and dbg_data_o to the oldest byte in the FIFO.
REQ-025 SHALL pop the FIFO at an edge where dbg_valid_o=1 and dbg_ready_i=1.
REQ-026 SHALL keep dbg_data_o stable while dbg_valid_o=1 and dbg_ready_i=0.
REQ-027 SHALL leave count unchanged on a simultaneous push and pop.
REQ-028 SHALL wrap the FIFO pointers modulo the depth, with empty and full derived from count.
REQ-029 SHALL ignore dbg_ready_i while empty, with no underflow.

Reset
REQ-030 SHALL, while rst_n=0 and regardless of clk, force data_o=0, CYCLE=0, FIFO pointers and count=0, overflow=0 and dbg_valid_o=0.
REQ-031 SHALL leave RAM contents unreset (undefined after power-up, preserved across reset).
REQ-032 SHALL, on reset asserted mid-operation, discard an in-flight read or FIFO transfer; the first edge after rst_n rises SHALL behave as cycle 0, with CYCLE becoming 1.

Verification
REQ-033 SHALL test RAM write/read: write 0xDEAD_BEEF to 0x0000_0010, read 0x0000_0013 next cycle -> data_o=0xDEAD_BEEF one cycle after the read; data_o holds through a following idle cycle.
REQ-034 SHALL test aliasing and unmapped reads: write 0x1234_5678 to 0x0000_0400 (ADDR_W=8) -> read 0x0000_0000 returns 0x1234_5678; read 0x8000_0000 -> data_o=0.
REQ-035 SHALL test the CYCLE counter: write 0xFFFF_FFFE to CYCLE, then read CYCLE on the second following edge -> data_o=0xFFFF_FFFF; a read one edge later -> 0x0000_0000.
REQ-036 SHALL test FIFO fill and overflow: dbg_ready_i=0, write bytes 0x01..0x09 to TXDATA -> STATUS reads count=8, full=1, overflow=1; with dbg_ready_i=1, drained bytes are exactly 0x01..0x08, then empty=1 and dbg_valid_o=0.
REQ-037 SHALL test push/pop at full: FIFO full, dbg_ready_i=1, write 0xAA -> accepted, count stays 8, overflow stays 0, and 0xAA is drained last.
REQ-038 SHALL test asynchronous reset: assert rst_n=0 between clock edges with the FIFO holding 3 bytes -> dbg_valid_o=0 and data_o=0 immediately; a RAM word written before reset still reads back its value.

Source files
------------

// File: rtl/riscv_data_mem.sv
// Data memory for a small RISC-V core: word RAM plus a memory-mapped
// cycle counter, a debug TX byte FIFO and a status register.
module riscv_data_mem #(
  parameter int ADDR_W      = 8,
  parameter int FIFO_D_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        dbg_valid_o,
  output logic [7:0]  dbg_data_o,
  input  logic        dbg_ready_i
);

  localparam int RAM_WORDS = 1 << ADDR_W;
  localparam int DEPTH     = 1 << FIFO_D_LOG2;

  localparam logic [31:0] CYCLE_ADDR  = 32'hF000_0000;
  localparam logic [31:0] TXDATA_ADDR = 32'hF000_0004;
  localparam logic [31:0] STATUS_ADDR = 32'hF000_0008;

  // Occupancy value meaning "full"
  localparam logic [FIFO_D_LOG2:0] FULL_CNT = {1'b1, {FIFO_D_LOG2{1'b0}}};

  // ------------------------------------------------------------------
  // Address decode (byte offset bits are ignored)
  // ------------------------------------------------------------------
  logic              sel_ram;
  logic              sel_cycle;
  logic              sel_tx;
  logic              sel_status;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] ram_idx;
  logic              unused_addr;

  assign sel_ram     = (addr_i[31:28] == 4'h0);
  assign sel_cycle   = (addr_i[31:2] == CYCLE_ADDR[31:2]);
  assign sel_tx      = (addr_i[31:2] == TXDATA_ADDR[31:2]);
  assign sel_status  = (addr_i[31:2] == STATUS_ADDR[31:2]);
  assign rd_en       = ce_i & ~we_i;
  assign wr_en       = ce_i & we_i;
  assign ram_idx     = addr_i[ADDR_W+1:2];
  assign unused_addr = &{1'b0, addr_i[1:0]};

  // ------------------------------------------------------------------
  // Word RAM: no reset, registered read port
  // ------------------------------------------------------------------
  logic [31:0] ram_mem [RAM_WORDS];
  logic [31:0] ram_rd_reg;

  // RAM write and registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && sel_ram) begin
      ram_mem[ram_idx] <= data_i;
    end
    if (rd_en && sel_ram) begin
      ram_rd_reg <= ram_mem[ram_idx];
    end
  end

  // ------------------------------------------------------------------
  // Cycle counter
  // ------------------------------------------------------------------
  logic [31:0] cycle_reg;

  // Free-running counter; a write replaces the increment for that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_reg <= 32'h0;
    end else if (wr_en && sel_cycle) begin
      cycle_reg <= data_i;
    end else begin
      cycle_reg <= cycle_reg + 32'h1;
    end
  end

  // ------------------------------------------------------------------
  // Debug TX FIFO
  // ------------------------------------------------------------------
  logic [7:0]             fifo_mem [DEPTH];
  logic [FIFO_D_LOG2-1:0] wr_ptr_reg;
  logic [FIFO_D_LOG2-1:0] rd_ptr_reg;
  logic [FIFO_D_LOG2:0]   count_reg;
  logic                   ovf_reg;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;
  logic                   push_req;
  logic                   push;
  logic                   ovf_set;
  logic                   status_wr;
  logic [DEPTH-1:0]       slot_we;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign pop        = ~fifo_empty & dbg_ready_i;
  assign push_req   = wr_en & sel_tx;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push       = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & ~push;
  assign status_wr  = wr_en & sel_status;

  // Per-slot write enables decoded from the write pointer
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
    assign slot_we[gi] = push & (wr_ptr_reg == FIFO_D_LOG2'(gi));
  end

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_we[i]) begin
        fifo_mem[i] <= data_i[7:0];
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop keeps count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= (ovf_reg & ~status_wr) | ovf_set;
    end
  end

  assign dbg_valid_o = ~fifo_empty;
  assign dbg_data_o  = fifo_mem[rd_ptr_reg];

  // ------------------------------------------------------------------
  // Read path: RAM data comes from the RAM output register, everything
  // else from a small register loaded on non-RAM reads
  // ------------------------------------------------------------------
  logic [4:0]  status_count;
  logic [31:0] status_word;
  logic [31:0] misc_rd_next;
  logic [31:0] misc_rd_reg;
  logic        ram_sel_reg;

  assign status_count = 5'(count_reg);
  assign status_word  = {19'b0, status_count, 5'b0, ovf_reg, fifo_full, fifo_empty};

  // Value of the non-RAM register being read (TXDATA and unmapped read 0)
  always_comb begin
    misc_rd_next = 32'h0;
    if (sel_cycle) begin
      misc_rd_next = cycle_reg;
    end else if (sel_status) begin
      misc_rd_next = status_word;
    end
  end

  // Capture read source and value; held when there is no read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_sel_reg <= 1'b0;
      misc_rd_reg <= 32'h0;
    end else if (rd_en) begin
      ram_sel_reg <= sel_ram;
      misc_rd_reg <= misc_rd_next;
    end
  end

  assign data_o = ram_sel_reg ? ram_rd_reg : misc_rd_reg;

endmodule
